// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle adder/subtractor. Adds two WIDTH-bit operands plus carry-in,
// CHUNK bits per clock, with the carry between chunks held in a register.
// This keeps the critical path at one CHUNK-bit add. A result takes
// N = WIDTH/CHUNK cycles from an accepted start to the done pulse.
//
// Parameters
//   WIDTH  operand/result width (multiple of CHUNK, >= 2)
//   CHUNK  bits added per cycle (1..WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle (busy=0)
//   Sub    0: A+B+Cin, 1: A+~B+Cin (captured with start)
//   A, B   operands (captured with start)
//   Cin    carry-in (captured with start)
//   busy   operation in progress
//   done   one-cycle pulse when S/Cout/V are updated
//   S      registered sum, holds the last completed result
//   Cout   carry out of bit WIDTH-1
//   V      signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted for subtract
    logic [WIDTH-1:0] res_reg;    // partial sum, never visible on S
    logic [WIDTH-1:0] res_upd;    // partial sum with this cycle's chunk merged
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             v_reg;
    logic             done_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [CHUNK-1:0] a_chunk [N];
    logic [CHUNK-1:0] b_chunk [N];
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic [CHUNK-1:0] r_cur;
    logic             c_cur;
    logic             c_msb;      // carry into bit WIDTH-1 (valid in last chunk)
    logic             last;

    // Slice operands into chunks; each result chunk is replaced only on its step.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign res_upd[gi*CHUNK +: CHUNK] =
                (idx_reg == IDX_W'(gi)) ? r_cur : res_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_cur = a_chunk[idx_reg];
    assign b_cur = b_chunk[idx_reg];
    assign {c_cur, r_cur} = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
    assign last = (idx_reg == IDX_W'(N - 1));

    // Carry into the chunk's top bit: re-add the lower CHUNK-1 bits and take
    // their carry. With single-bit chunks it is simply the incoming carry.
    generate
        if (CHUNK == 1) begin : g_msb_c1
            assign c_msb = carry_reg;
        end else begin : g_msb_cn
            logic [CHUNK-1:0] low_sum;
            assign low_sum = {1'b0, a_cur[CHUNK-2:0]} + {1'b0, b_cur[CHUNK-2:0]}
                           + {{(CHUNK-1){1'b0}}, carry_reg};
            assign c_msb = low_sum[CHUNK-1];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_reg == RUN);
        done = done_reg;
        S    = s_reg;
        Cout = cout_reg;
        V    = v_reg;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            v_reg     <= 1'b0;
            done_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B ^ {WIDTH{Sub}};
                        carry_reg <= Cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    res_reg   <= res_upd;
                    carry_reg <= c_cur;
                    idx_reg   <= idx_reg + IDX_W'(1);
                    if (last) begin
                        s_reg    <= res_upd;
                        cout_reg <= c_cur;
                        v_reg    <= c_msb ^ c_cur;
                        done_reg <= 1'b1;
                        idx_reg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub_in = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        cin = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Main instance WIDTH=16, CHUNK=4
    logic busy, done, cout, v;
    logic [15:0] s;
    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(sub_in), .A(a_in), .B(b_in),
        .Cin(cin), .busy(busy), .done(done), .S(s), .Cout(cout), .V(v));

    // Sweep instances sharing the same stimulus
    logic busy_1, done_1, cout_1, v_1;
    logic [15:0] s_1;
    chunked_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(sub_in), .A(a_in), .B(b_in),
        .Cin(cin), .busy(busy_1), .done(done_1), .S(s_1), .Cout(cout_1), .V(v_1));

    logic busy_2, done_2, cout_2, v_2;
    logic [15:0] s_2;
    chunked_adder #(.WIDTH(16), .CHUNK(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(sub_in), .A(a_in), .B(b_in),
        .Cin(cin), .busy(busy_2), .done(done_2), .S(s_2), .Cout(cout_2), .V(v_2));

    logic busy_16, done_16, cout_16, v_16;
    logic [15:0] s_16;
    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(sub_in), .A(a_in), .B(b_in),
        .Cin(cin), .busy(busy_16), .done(done_16), .S(s_16), .Cout(cout_16), .V(v_16));

    logic busy_w8, done_w8, cout_w8, v_w8;
    logic [7:0] s_w8;
    chunked_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(sub_in), .A(a_in[7:0]), .B(b_in[7:0]),
        .Cin(cin), .busy(busy_w8), .done(done_w8), .S(s_w8), .Cout(cout_w8), .V(v_w8));

    // Present an operation and return just after its accepting edge.
    task automatic go(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
        a_in = a; b_in = b; cin = c; sub_in = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for the main instance's done; counts cycles and busy cycles.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        #12;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (s !== 16'h0000) begin n_err++; $display("FAIL reset_s got %h want 0000", s); end
        n_vec++; if ({cout, v} !== 2'b00) begin n_err++; $display("FAIL reset_cv got %b want 00", {cout, v}); end
        $display("reset: busy=%b done=%b S=%h Cout=%b V=%b", busy, done, s, cout, v);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [15:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
        logic [15:0] tb [4] = '{16'h4321, 16'h0000, 16'h0001, 16'h0007};
        logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [4] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE};
        logic [1:0]  ecv [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
        int cyc, bc;
        for (int i = 0; i < 4; i++) begin
            go(ta[i], tb[i], tc[i], ts[i]);
            wait_done(cyc, bc);
            $display("add %0d: A=%h B=%h Cin=%b Sub=%b -> S=%h Cout=%b V=%b lat=%0d",
                     i, ta[i], tb[i], tc[i], ts[i], s, cout, v, cyc);
            n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL add%0d_latency got %0d want 4", i, cyc); end
            n_vec++; if (bc !== 4) begin n_err++; $display("FAIL add%0d_busy_cycles got %0d want 4", i, bc); end
            n_vec++; if (s !== es[i]) begin n_err++; $display("FAIL add%0d_s got %h want %h", i, s, es[i]); end
            n_vec++; if ({cout, v} !== ecv[i]) begin n_err++; $display("FAIL add%0d_cout_v got %b want %b", i, {cout, v}, ecv[i]); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL add%0d_done_width got %b want 0", i, done); end
        end
    endtask

    task automatic test_ignore_busy();
        int cyc, bc;
        go(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_in = 16'h1111; b_in = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bc);
        $display("ignore: S=%h Cout=%b V=%b lat=%0d", s, cout, v, cyc + 2);
        n_vec++; if (cyc + 2 !== 4) begin n_err++; $display("FAIL ignore_latency got %0d want 4", cyc + 2); end
        n_vec++; if (s !== 16'h5555) begin n_err++; $display("FAIL ignore_s got %h want 5555", s); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s;
        a_in = 16'h0001; b_in = 16'h0002; cin = 1'b0; sub_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a_in = 16'h0010;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            exp_s = (c < 4) ? 16'h5555 : (c < 9) ? 16'h0003 : 16'h0012;
            n_vec++; if (done !== (c == 4 || c == 9)) begin n_err++; $display("FAIL b2b_done_c%0d got %b want %b", c, done, (c == 4 || c == 9)); end
            n_vec++; if (s !== exp_s) begin n_err++; $display("FAIL b2b_s_c%0d got %h want %h", c, s, exp_s); end
        end
        start = 1'b0;
        $display("b2b: second result S=%h", s);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int pulses, cyc, bc;
        go(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rstmid_busy_done got %b want 00", {busy, done}); end
        n_vec++; if (s !== 16'h0000) begin n_err++; $display("FAIL rstmid_s got %h want 0000", s); end
        n_vec++; if ({cout, v} !== 2'b00) begin n_err++; $display("FAIL rstmid_cv got %b want 00", {cout, v}); end
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_no_done got %0d pulses want 0", pulses); end
        go(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc, bc);
        $display("rstmid: recovery S=%h Cout=%b V=%b lat=%0d", s, cout, v, cyc);
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL rstmid_latency got %0d want 4", cyc); end
        n_vec++; if ({cout, v, s} !== {2'b01, 16'h8000}) begin n_err++; $display("FAIL rstmid_result got %b_%b_%h want 0_1_8000", cout, v, s); end
    endtask

    task automatic test_sweep();
        logic [15:0] ta [2] = '{16'hA5C3, 16'h00FF};
        logic [15:0] tb [2] = '{16'h3C5A, 16'h0001};
        logic        tc [2] = '{1'b1, 1'b0};
        logic        ts [2] = '{1'b1, 1'b0};
        logic [17:0] e16 [2] = '{{2'b11, 16'h6969}, {2'b00, 16'h0100}};
        logic [9:0]  e8 [2]  = '{{2'b11, 8'h69}, {2'b10, 8'h00}};
        int l1, l2, l4, l16, l8;
        for (int i = 0; i < 2; i++) begin
            rst_n = 1'b0; #2; @(negedge clk); rst_n = 1'b1;
            @(posedge clk); #1;
            go(ta[i], tb[i], tc[i], ts[i]);
            l1 = -1; l2 = -1; l4 = -1; l16 = -1; l8 = -1;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (done_1 === 1'b1 && l1 < 0) l1 = c;
                if (done_2 === 1'b1 && l2 < 0) l2 = c;
                if (done === 1'b1 && l4 < 0) l4 = c;
                if (done_16 === 1'b1 && l16 < 0) l16 = c;
                if (done_w8 === 1'b1 && l8 < 0) l8 = c;
                if (l1 >= 0 && l2 >= 0 && l4 >= 0 && l16 >= 0 && l8 >= 0) break;
            end
            $display("sweep %0d: lat c1=%0d c2=%0d c4=%0d c16=%0d w8=%0d S=%h/%h/%h/%h/%h",
                     i, l1, l2, l4, l16, l8, s_1, s_2, s, s_16, s_w8);
            n_vec++; if (l1 !== 16) begin n_err++; $display("FAIL sweep%0d_c1_latency got %0d want 16", i, l1); end
            n_vec++; if (l2 !== 8) begin n_err++; $display("FAIL sweep%0d_c2_latency got %0d want 8", i, l2); end
            n_vec++; if (l4 !== 4) begin n_err++; $display("FAIL sweep%0d_c4_latency got %0d want 4", i, l4); end
            n_vec++; if (l16 !== 1) begin n_err++; $display("FAIL sweep%0d_c16_latency got %0d want 1", i, l16); end
            n_vec++; if (l8 !== 1) begin n_err++; $display("FAIL sweep%0d_w8_latency got %0d want 1", i, l8); end
            n_vec++; if ({cout_1, v_1, s_1} !== e16[i]) begin n_err++; $display("FAIL sweep%0d_c1_result got %h want %h", i, {cout_1, v_1, s_1}, e16[i]); end
            n_vec++; if ({cout_2, v_2, s_2} !== e16[i]) begin n_err++; $display("FAIL sweep%0d_c2_result got %h want %h", i, {cout_2, v_2, s_2}, e16[i]); end
            n_vec++; if ({cout, v, s} !== e16[i]) begin n_err++; $display("FAIL sweep%0d_c4_result got %h want %h", i, {cout, v, s}, e16[i]); end
            n_vec++; if ({cout_16, v_16, s_16} !== e16[i]) begin n_err++; $display("FAIL sweep%0d_c16_result got %h want %h", i, {cout_16, v_16, s_16}, e16[i]); end
            n_vec++; if ({cout_w8, v_w8, s_w8} !== e8[i]) begin n_err++; $display("FAIL sweep%0d_w8_result got %h want %h", i, {cout_w8, v_w8, s_w8}, e8[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle, parametrised successor to the combinational full adder: adds two WIDTH-bit operands plus carry-in by rippling CHUNK bits per clock through a registered carry, trading latency for a short critical path. Supports add and subtract mode and reports carry-out and signed overflow. Sits in the arithmetic datapath wherever a wide add is not timing-critical and a start/done handshake is acceptable.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK, ≥ 2
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- Sub  input  1  0: A+B+Cin; 1: A+~B+Cin (Cin=1 gives A−B)
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Cin  input  1  carry-in, captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- S  output  WIDTH  sum, registered
- Cout  output  1  carry out of bit WIDTH−1
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- N = WIDTH/CHUNK chunk steps; chunk index idx, width clog2(N) (min 1).
- States: IDLE, RUN.
- IDLE: busy=0. On start=1: latch A, B^{WIDTH{Sub}}, Cin into carry register, idx←0, go RUN. Sub, A, B, Cin ignored after capture.
- RUN: busy=1. Each cycle: {c, r} = A[idx chunk] + B'[idx chunk] + carry, all CHUNK+1 bits wide; write r into internal result at chunk idx; carry←c; idx←idx+1. On idx=N−1: also record carry into MSB (bit WIDTH−2→WIDTH−1), copy full result to S, Cout←c, V←carry_into_MSB ^ c, pulse done, return to IDLE.
- Carry into MSB derived within the last chunk (CHUNK=1: equals incoming carry register).
- start while busy=1: ignored, no queueing.
- S, Cout, V hold last completed result until the next completion; never show partial sums.
- Sub=1, Cin=0 gives A+~B (one's complement difference); not an error.

## Timing
- Reset (rst_n=0, any time, async): state←IDLE, busy=0, done=0, S=0, Cout=0, V=0, idx=0, carry=0. Reset mid-operation aborts; no done pulse; S retains 0.
- Start accepted at edge k: busy=1 after edge k; chunks processed at edges k+1…k+N; after edge k+N: busy=0, done=1, S/Cout/V valid.
- done high exactly one cycle (edge k+N to k+N+1).
- Latency start→done = N cycles; throughput one result per N+1 cycles minimum, since start is sampled in the done cycle (busy=0 there) and accepted at edge k+N+1.
- start held high continuously: back-to-back operations, each N cycles of busy then one IDLE cycle.
- CHUNK=WIDTH: N=1, done one cycle after start.

## Test plan
- WIDTH=16, CHUNK=4: A=0x1234, B=0x4321, Cin=0, Sub=0 -> after 4 cycles done=1, S=0x5555, Cout=0, V=0; busy high exactly 4 cycles.
- A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1, V=0 (carry ripples through all chunks).
- A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, V=1; then Sub=1, Cin=1, A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0, V=0.
- start pulsed again while busy with different A/B -> ignored, first result unchanged; start held high -> done pulses every 5 cycles, S updates only at done.
- rst_n low during 2nd chunk of a run -> busy, done, S, Cout, V immediately 0, no done pulse; next start completes normally.
- Parameter sweep (CHUNK=1,2,4,16 at WIDTH=16; WIDTH=8, CHUNK=8): random A, B, Cin, Sub vs reference {Cout,S}=A+(B^Sub)+Cin and V, latency = WIDTH/CHUNK.
